matrix_mem_banked: RTL and testbench

//  Parametrised main-memory successor: DEPTH entries, each one DIMxDIM matrix of ELEM_W-bit elements.

---
 rtl/mm_pkg.sv | 26 ++
 rtl/mm_rd_pipe.sv | 41 ++++
 rtl/matrix_mem_banked.sv | 137 +++++++++++++
 tb/tb_matrix_mem_banked.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// Shared types and constants for the banked matrix memory.
// Default-size element/matrix typedefs serve testbenches and neighbouring bus modules.
package mm_pkg;

  localparam int unsigned MODSEL_MSB = 15;
  localparam int unsigned MODSEL_LSB = 12;
  localparam int unsigned IDX_W      = 12;

  localparam int unsigned DEF_ELEM_W = 16;
  localparam int unsigned DEF_DIM    = 4;

  typedef logic [DEF_ELEM_W-1:0]      elem_t;
  typedef elem_t [DEF_DIM*DEF_DIM-1:0] matrix_t;

  typedef logic [0:0] mm_state_e;
  localparam mm_state_e MM_CLEAR = 1'b0;
  localparam mm_state_e MM_READY = 1'b1;

  // One extra bit so DEPTH=4096 still compares correctly against a 12-bit index.
  function automatic logic idx_in_range(input logic [IDX_W-1:0] idx, input int unsigned depth);
    logic [IDX_W:0] lim;
    lim = (IDX_W+1)'(depth);
    return {1'b0, idx} < lim;
  endfunction

endpackage

// File: rtl/mm_rd_pipe.sv
// Read return delay line: LAT register stages of valid+data, flushed by synchronous reset.
// Data stages only load when their input is valid, so the output holds between results.
module mm_rd_pipe #(
  parameter int unsigned WIDTH = 256,
  parameter int unsigned LAT   = 1
) (
  input  logic             Clk,
  input  logic             nReset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [LAT-1:0]   valid_q;
  logic [WIDTH-1:0] data_q [LAT];

  always_ff @(posedge Clk) begin
    if (!nReset) begin
      valid_q <= '0;
      for (int i = 0; i < int'(LAT); i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= in_valid;
      if (in_valid) begin
        data_q[0] <= in_data;
      end
      for (int i = 1; i < int'(LAT); i++) begin
        valid_q[i] <= valid_q[i-1];
        if (valid_q[i-1]) begin
          data_q[i] <= data_q[i-1];
        end
      end
    end
  end

  assign out_valid = valid_q[LAT-1];
  assign out_data  = data_q[LAT-1];

endmodule

// File: rtl/matrix_mem_banked.sv
// Bus-decoded matrix memory: masked per-element writes, pipelined reads, and a clear sequencer
// that initialises every entry after reset or on request.
module matrix_mem_banked
  import mm_pkg::*;
#(
  parameter int unsigned ELEM_W = 16,
  parameter int unsigned DIM    = 4,
  parameter int unsigned DEPTH  = 16,
  parameter logic [3:0]  MOD_ID = 4'h0,
  parameter int unsigned RD_LAT = 1,
  localparam int unsigned MW    = DIM * DIM * ELEM_W,
  parameter logic [MW-1:0] INIT0 = '0,
  parameter logic [MW-1:0] INIT1 = '0
) (
  input  logic               Clk,
  input  logic               nReset,
  input  logic [15:0]        address,
  input  logic               nRead,
  input  logic               nWrite,
  input  logic               nClear,
  input  logic [MW-1:0]      DataIn,
  input  logic [DIM*DIM-1:0] ElemMask,
  output logic [MW-1:0]      DataOut,
  output logic               RdValid,
  output logic               Busy,
  output logic               Err
);

  localparam int          NE = int'(DIM * DIM);
  localparam int unsigned CW = $clog2(DEPTH);

  logic [MW-1:0] mem [DEPTH];

  mm_state_e     state_q;
  logic [CW-1:0] cnt_q;
  logic          err_q;

  logic          sel;
  logic          rd_req;
  logic          wr_req;
  logic          idx_ok;
  logic          busy;
  logic          clr_req;
  logic          rd_ok;
  logic          wr_ok;
  logic          err_d;
  logic [CW-1:0] idx;
  logic [MW-1:0] clr_data;
  logic [MW-1:0] rd_word;

  // Request decode and acceptance
  always_comb begin
    sel     = (address[MODSEL_MSB:MODSEL_LSB] == MOD_ID);
    rd_req  = sel && !nRead;
    wr_req  = sel && !nWrite;
    idx_ok  = idx_in_range(address[IDX_W-1:0], DEPTH);
    idx     = address[CW-1:0];
    busy    = (state_q == MM_CLEAR);
    // A clear request wins over same-cycle accesses, which vanish silently.
    clr_req = (state_q == MM_READY) && !nClear;
    rd_ok   = nReset && rd_req && !busy && !clr_req && idx_ok;
    wr_ok   = nReset && wr_req && !busy && !clr_req && idx_ok;
    err_d   = (rd_req || wr_req) && !clr_req && (busy || !idx_ok);
  end

  always_comb begin
    clr_data = '0;
    if (cnt_q == '0) begin
      clr_data = INIT0;
    end else if (cnt_q == CW'(1)) begin
      clr_data = INIT1;
    end
  end

  // Clear sequencer and error pulse
  always_ff @(posedge Clk) begin
    if (!nReset) begin
      state_q <= MM_CLEAR;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= err_d;
      case (state_q)
        MM_CLEAR: begin
          if (cnt_q == CW'(DEPTH - 1)) begin
            state_q <= MM_READY;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        MM_READY: begin
          if (!nClear) begin
            state_q <= MM_CLEAR;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= MM_CLEAR;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Storage is never reset directly; the clear sequencer initialises it.
  always_ff @(posedge Clk) begin
    if (nReset && busy) begin
      mem[cnt_q] <= clr_data;
    end else if (wr_ok) begin
      for (int k = 0; k < NE; k++) begin
        if (ElemMask[k]) begin
          mem[idx][k*ELEM_W +: ELEM_W] <= DataIn[k*ELEM_W +: ELEM_W];
        end
      end
    end
  end

  // Captured at the request edge, so a same-edge write is not yet visible.
  assign rd_word = mem[idx];

  mm_rd_pipe #(
    .WIDTH (MW),
    .LAT   (RD_LAT)
  ) u_rd_pipe (
    .Clk       (Clk),
    .nReset    (nReset),
    .in_valid  (rd_ok),
    .in_data   (rd_word),
    .out_valid (RdValid),
    .out_data  (DataOut)
  );

  assign Busy = busy;
  assign Err  = err_q;

endmodule

// File: tb/tb_matrix_mem_banked.sv
// Scoreboard bench: two instances (DEPTH=16/RD_LAT=1 and DEPTH=12/RD_LAT=3) driven by directed
// vectors; expected read data and Err pulses are queued with their due cycle and popped by monitors.
module tb_matrix_mem_banked;

  typedef logic [255:0] mw_t;
  typedef struct {
    int  cyc;
    mw_t data;
  } exp_t;

  localparam mw_t A_VAL = 256'h1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0001;
  localparam mw_t B_VAL = 256'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_0F0F_F0F0_1234_5678_9ABC_DEF0_CAFE_BEEF;
  localparam mw_t ALL_F = {16{16'hFFFF}};
  localparam mw_t LOW4  = 256'hFFFF_FFFF_FFFF_FFFF;
  localparam mw_t A_P   = 256'hFFFF_2222_3333_4444_5555_6666_7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_FFFF;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic        a_nReset, a_nRead, a_nWrite, a_nClear, a_RdValid, a_Busy, a_Err;
  logic [15:0] a_address, a_ElemMask;
  mw_t         a_DataIn, a_DataOut;
  logic        b_nReset, b_nRead, b_nWrite, b_nClear, b_RdValid, b_Busy, b_Err;
  logic [15:0] b_address, b_ElemMask;
  mw_t         b_DataIn, b_DataOut;

  matrix_mem_banked #(
    .ELEM_W (16), .DIM (4), .DEPTH (16), .MOD_ID (4'h0), .RD_LAT (1),
    .INIT0  (A_VAL), .INIT1 (B_VAL)
  ) dut_a (
    .Clk (Clk), .nReset (a_nReset), .address (a_address), .nRead (a_nRead),
    .nWrite (a_nWrite), .nClear (a_nClear), .DataIn (a_DataIn), .ElemMask (a_ElemMask),
    .DataOut (a_DataOut), .RdValid (a_RdValid), .Busy (a_Busy), .Err (a_Err)
  );

  matrix_mem_banked #(
    .ELEM_W (16), .DIM (4), .DEPTH (12), .MOD_ID (4'h0), .RD_LAT (3),
    .INIT0  (B_VAL), .INIT1 (A_VAL)
  ) dut_b (
    .Clk (Clk), .nReset (b_nReset), .address (b_address), .nRead (b_nRead),
    .nWrite (b_nWrite), .nClear (b_nClear), .DataIn (b_DataIn), .ElemMask (b_ElemMask),
    .DataOut (b_DataOut), .RdValid (b_RdValid), .Busy (b_Busy), .Err (b_Err)
  );

  exp_t qa[$];
  exp_t qb[$];
  int   qa_err[$];
  int   qb_err[$];

  task automatic chk_mw(input string name, input mw_t act, input mw_t expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, expv);
    end
  endtask

  task automatic apply(input int d, input bit rd, input bit wr, input bit clr,
                       input logic [15:0] addr, input mw_t data, input logic [15:0] mask);
    if (d == 0) begin
      a_nRead = ~rd; a_nWrite = ~wr; a_nClear = ~clr;
      a_address = addr; a_DataIn = data; a_ElemMask = mask;
    end else begin
      b_nRead = ~rd; b_nWrite = ~wr; b_nClear = ~clr;
      b_address = addr; b_DataIn = data; b_ElemMask = mask;
    end
  endtask

  task automatic drive(input int d, input bit rd, input bit wr, input bit clr,
                       input logic [15:0] addr, input mw_t data, input logic [15:0] mask);
    @(negedge Clk);
    apply(d, rd, wr, clr, addr, data, mask);
  endtask

  task automatic idle(input int d);
    drive(d, 1'b0, 1'b0, 1'b0, 16'h0000, '0, 16'h0000);
  endtask

  // Called right after drive(): the request is sampled on the next edge.
  task automatic exp_rd(input int d, input mw_t data);
    exp_t e;
    e.data = data;
    e.cyc  = cyc + ((d == 0) ? 1 : 3);
    if (d == 0) qa.push_back(e);
    else qb.push_back(e);
  endtask

  task automatic exp_err(input int d);
    if (d == 0) qa_err.push_back(cyc + 1);
    else qb_err.push_back(cyc + 1);
  endtask

  task automatic busy_count(input int d, output int n);
    n = 0;
    while (((d == 0) ? a_Busy : b_Busy) && n < 100) begin
      n++;
      @(posedge Clk);
      #1;
    end
  endtask

  exp_t ea;
  always @(posedge Clk) begin
    #1;
    if (qa.size() != 0 && qa[0].cyc < cyc) begin
      checks++; errors++;
      $display("FAIL a_rdvalid_missing: got none at cycle %0d expected data %h", qa[0].cyc, qa[0].data);
      void'(qa.pop_front());
    end
    if (a_RdValid === 1'b1) begin
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_rdvalid_unexpected: got data %h at cycle %0d expected none", a_DataOut, cyc);
      end else begin
        ea = qa.pop_front();
        chk_mw("a_rd_data", a_DataOut, ea.data);
        chk_int("a_rd_cycle", cyc, ea.cyc);
      end
    end
    if (qa_err.size() != 0 && qa_err[0] < cyc) begin
      checks++; errors++;
      $display("FAIL a_err_missing: got none at cycle %0d expected pulse", qa_err[0]);
      void'(qa_err.pop_front());
    end
    if (a_Err === 1'b1) begin
      if (qa_err.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_err_unexpected: got pulse at cycle %0d expected none", cyc);
      end else begin
        chk_int("a_err_cycle", cyc, qa_err.pop_front());
      end
    end
  end

  exp_t eb;
  always @(posedge Clk) begin
    #1;
    if (qb.size() != 0 && qb[0].cyc < cyc) begin
      checks++; errors++;
      $display("FAIL b_rdvalid_missing: got none at cycle %0d expected data %h", qb[0].cyc, qb[0].data);
      void'(qb.pop_front());
    end
    if (b_RdValid === 1'b1) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_rdvalid_unexpected: got data %h at cycle %0d expected none", b_DataOut, cyc);
      end else begin
        eb = qb.pop_front();
        chk_mw("b_rd_data", b_DataOut, eb.data);
        chk_int("b_rd_cycle", cyc, eb.cyc);
      end
    end
    if (qb_err.size() != 0 && qb_err[0] < cyc) begin
      checks++; errors++;
      $display("FAIL b_err_missing: got none at cycle %0d expected pulse", qb_err[0]);
      void'(qb_err.pop_front());
    end
    if (b_Err === 1'b1) begin
      if (qb_err.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_err_unexpected: got pulse at cycle %0d expected none", cyc);
      end else begin
        chk_int("b_err_cycle", cyc, qb_err.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    apply(0, 1'b0, 1'b0, 1'b0, 16'h0000, '0, 16'h0000);
    apply(1, 1'b0, 1'b0, 1'b0, 16'h0000, '0, 16'h0000);
    a_nReset = 1'b0;
    b_nReset = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk_mw("a_reset_dataout", a_DataOut, '0);
    chk_bit("a_reset_rdvalid", a_RdValid, 1'b0);
    chk_bit("a_reset_err", a_Err, 1'b0);
    chk_bit("a_reset_busy", a_Busy, 1'b1);
    a_nReset = 1'b1;
    b_nReset = 1'b1;
    busy_count(0, n);
    chk_int("a_busy_cycles_reset", n, 16);

    // Initial contents, back-to-back reads
    drive(0, 1, 0, 0, 16'h0000, '0, 16'h0000); exp_rd(0, A_VAL);
    drive(0, 1, 0, 0, 16'h0001, '0, 16'h0000); exp_rd(0, B_VAL);
    drive(0, 1, 0, 0, 16'h000F, '0, 16'h0000); exp_rd(0, '0);
    // Masked write, then mask=0 no-op
    drive(0, 0, 1, 0, 16'h0005, ALL_F, 16'h000F);
    drive(0, 1, 0, 0, 16'h0005, '0, 16'h0000); exp_rd(0, LOW4);
    drive(0, 0, 1, 0, 16'h0005, A_VAL, 16'h0000);
    drive(0, 1, 0, 0, 16'h0005, '0, 16'h0000); exp_rd(0, LOW4);
    // Read-before-write on the same entry
    drive(0, 0, 1, 0, 16'h0003, B_VAL, 16'hFFFF);
    drive(0, 1, 1, 0, 16'h0003, A_VAL, 16'hFFFF); exp_rd(0, B_VAL);
    drive(0, 1, 0, 0, 16'h0003, '0, 16'h0000); exp_rd(0, A_VAL);
    drive(0, 0, 1, 0, 16'h0003, ALL_F, 16'h8001);
    drive(0, 1, 0, 0, 16'h0003, '0, 16'h0000); exp_rd(0, A_P);
    // Range errors and unselected accesses
    drive(0, 1, 0, 0, 16'h0010, '0, 16'h0000); exp_err(0);
    drive(0, 1, 0, 0, 16'h1010, '0, 16'h0000);
    drive(0, 1, 1, 0, 16'h0020, ALL_F, 16'hFFFF); exp_err(0);
    drive(0, 0, 1, 0, 16'h1000, ALL_F, 16'hFFFF);
    drive(0, 1, 0, 0, 16'h0000, '0, 16'h0000); exp_rd(0, A_VAL);
    // Clear with a same-cycle write: write dropped, no Err
    drive(0, 0, 1, 1, 16'h0005, A_VAL, 16'hFFFF);
    idle(0);
    busy_count(0, n);
    chk_int("a_busy_cycles_clear", n, 16);
    drive(0, 1, 0, 0, 16'h0005, '0, 16'h0000); exp_rd(0, '0);
    drive(0, 1, 0, 0, 16'h0000, '0, 16'h0000); exp_rd(0, A_VAL);
    drive(0, 1, 0, 0, 16'h0003, '0, 16'h0000); exp_rd(0, '0);
    drive(0, 1, 0, 0, 16'h0001, '0, 16'h0000); exp_rd(0, B_VAL);
    idle(0);

    // Instance B: DEPTH=12, RD_LAT=3
    drive(1, 1, 0, 0, 16'h0000, '0, 16'h0000); exp_rd(1, B_VAL);
    drive(1, 1, 0, 0, 16'h0001, '0, 16'h0000); exp_rd(1, A_VAL);
    drive(1, 1, 0, 0, 16'h000B, '0, 16'h0000); exp_rd(1, '0);
    drive(1, 1, 0, 0, 16'h000C, '0, 16'h0000); exp_err(1);
    drive(1, 1, 0, 0, 16'h100C, '0, 16'h0000);
    drive(1, 0, 1, 0, 16'h0005, ALL_F, 16'h000F);
    drive(1, 1, 0, 0, 16'h0005, '0, 16'h0000); exp_rd(1, LOW4);
    repeat (4) idle(1);
    // Reset lands on the edge of the third read: nothing in flight may emerge
    drive(1, 1, 0, 0, 16'h0000, '0, 16'h0000);
    drive(1, 1, 0, 0, 16'h0001, '0, 16'h0000);
    drive(1, 1, 0, 0, 16'h0002, '0, 16'h0000);
    b_nReset = 1'b0;
    @(negedge Clk);
    chk_bit("b_reset_rdvalid", b_RdValid, 1'b0);
    chk_bit("b_reset_busy", b_Busy, 1'b1);
    chk_mw("b_reset_dataout", b_DataOut, '0);
    apply(1, 1'b0, 1'b0, 1'b0, 16'h0000, '0, 16'h0000);
    b_nReset = 1'b1;
    busy_count(1, n);
    chk_int("b_busy_cycles_reset", n, 12);
    drive(1, 1, 0, 0, 16'h0005, '0, 16'h0000); exp_rd(1, '0);
    drive(1, 1, 0, 0, 16'h0000, '0, 16'h0000); exp_rd(1, B_VAL);
    // Access while clearing is rejected
    drive(1, 0, 1, 0, 16'h0002, A_VAL, 16'hFFFF);
    drive(1, 1, 0, 0, 16'h0002, '0, 16'h0000); exp_rd(1, A_VAL);
    drive(1, 0, 0, 1, 16'h0000, '0, 16'h0000);
    drive(1, 1, 0, 0, 16'h0002, '0, 16'h0000); exp_err(1);
    idle(1);
    busy_count(1, n);
    chk_int("b_busy_cycles_clear", n, 11);
    drive(1, 1, 0, 0, 16'h0002, '0, 16'h0000); exp_rd(1, '0);
    drive(1, 1, 0, 0, 16'h0001, '0, 16'h0000); exp_rd(1, A_VAL);
    repeat (6) idle(1);

    chk_int("a_rd_queue_drained", qa.size(), 0);
    chk_int("b_rd_queue_drained", qb.size(), 0);
    chk_int("a_err_queue_drained", qa_err.size(), 0);
    chk_int("b_err_queue_drained", qb_err.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
